// File: rtl/mealy_event_counter.sv
// Windowed event counter: counts "111" (o_in[1]) and "001" (o_in[0]) detector hits over
// window_len cycles, then holds a valid/ready report. Optional ovf output via MEALY_EVENT_COUNTER_OVF_EN.
module mealy_event_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  input  logic [1:0]       o_in,
  output logic             busy,
  output logic             rep_valid,
  input  logic             rep_ready,
  output logic [CNT_W-1:0] rep_hi,
  output logic [CNT_W-1:0] rep_lo
`ifdef MEALY_EVENT_COUNTER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] COUNT  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt_hi, cnt_lo;
  logic [WIN_W-1:0] remaining;
  logic             hi_sat, lo_sat;

  assign hi_sat    = (cnt_hi == CMAX);
  assign lo_sat    = (cnt_lo == CMAX);
  assign busy      = (state != IDLE);
  // Registered state only, so rep_valid never sees rep_ready combinationally.
  assign rep_valid = (state == REPORT);
  assign rep_hi    = cnt_hi;
  assign rep_lo    = cnt_lo;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt_hi    <= '0;
      cnt_lo    <= '0;
      remaining <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt_hi    <= '0;
            cnt_lo    <= '0;
            remaining <= window_len;
            state     <= (window_len == '0) ? REPORT : COUNT;
          end
        end
        COUNT: begin
          if (o_in[1] && !hi_sat) cnt_hi <= cnt_hi + 1'b1;
          if (o_in[0] && !lo_sat) cnt_lo <= cnt_lo + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == WIN_W'(1)) state <= REPORT;
        end
        REPORT: begin
          if (rep_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEALY_EVENT_COUNTER_OVF_EN
  // Sticky across REPORT and the following IDLE; only a new accepted start clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      ovf <= 1'b0;
    else if (state == IDLE && start)
      ovf <= 1'b0;
    else if (state == COUNT && ((o_in[1] && hi_sat) || (o_in[0] && lo_sat)))
      ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mealy_event_counter.sv
// Directed bench for mealy_event_counter (CNT_W=4 so saturation is reachable in one window).
module tb_mealy_event_counter;
  localparam int CNT_W = 4;
  localparam int WIN_W = 8;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start;
  logic [WIN_W-1:0] window_len;
  logic [1:0]       o_in;
  logic             busy, rep_valid, rep_ready;
  logic [CNT_W-1:0] rep_hi, rep_lo;
`ifdef MEALY_EVENT_COUNTER_OVF_EN
  logic             ovf;
`endif

  int passed = 0;
  int total  = 0;

  mealy_event_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .window_len(window_len),
    .o_in(o_in), .busy(busy), .rep_valid(rep_valid), .rep_ready(rep_ready),
    .rep_hi(rep_hi), .rep_lo(rep_lo)
`ifdef MEALY_EVENT_COUNTER_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [1:0] seq [10];

  initial begin
    seq = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    reset_n = 1'b0; start = 1'b0; window_len = '0; o_in = 2'b00; rep_ready = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", rep_valid, 0);
    chk("rst_hi", rep_hi, 0);
    chk("rst_lo", rep_lo, 0);
`ifdef MEALY_EVENT_COUNTER_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    tick(); tick();
    reset_n = 1'b1;

    // 10-cycle window
    start = 1'b1; window_len = 8'd10;
    tick();
    chk("win_busy_start", busy, 1);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      o_in = seq[i];
      tick();
      chk($sformatf("win_busy_%0d", i), busy, 1);
      chk($sformatf("win_valid_%0d", i), rep_valid, (i == 9) ? 1 : 0);
    end
    o_in = 2'b00;
    chk("win_hi", rep_hi, 1);
    chk("win_lo", rep_lo, 2);
    rep_ready = 1'b1;
    tick();
    chk("win_done_busy", busy, 0);
    chk("win_done_valid", rep_valid, 0);
    rep_ready = 1'b0;

    // zero-length window goes straight to REPORT
    start = 1'b1; window_len = 8'd0;
    tick();
    start = 1'b0;
    chk("empty_valid", rep_valid, 1);
    chk("empty_hi", rep_hi, 0);
    chk("empty_lo", rep_lo, 0);
    rep_ready = 1'b1;
    tick();
    chk("empty_idle", busy, 0);
    rep_ready = 1'b0;

    // backpressure: REPORT holds, ignores o_in and start
    start = 1'b1; window_len = 8'd2;
    tick();
    start = 1'b0; o_in = 2'b01;
    tick(); tick();
    chk("bp_valid0", rep_valid, 1);
    chk("bp_lo0", rep_lo, 2);
    for (int i = 0; i < 5; i++) begin
      o_in = (i % 2 == 0) ? 2'b11 : 2'b00;
      start = 1'b1;
      tick();
      chk($sformatf("bp_valid_%0d", i), rep_valid, 1);
      chk($sformatf("bp_hi_%0d", i), rep_hi, 0);
      chk($sformatf("bp_lo_%0d", i), rep_lo, 2);
    end
    start = 1'b0; o_in = 2'b00;
    rep_ready = 1'b1;
    #1;
    chk("bp_valid_comb", rep_valid, 1);
    tick();
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_valid", rep_valid, 0);
    rep_ready = 1'b0;

    // saturation
    start = 1'b1; window_len = 8'd20;
    tick();
    start = 1'b0; o_in = 2'b11;
    for (int i = 0; i < 20; i++) tick();
    o_in = 2'b00;
    chk("sat_valid", rep_valid, 1);
    chk("sat_hi", rep_hi, 15);
    chk("sat_lo", rep_lo, 15);
`ifdef MEALY_EVENT_COUNTER_OVF_EN
    chk("sat_ovf", ovf, 1);
`endif
    rep_ready = 1'b1;
    tick();
    rep_ready = 1'b0;
`ifdef MEALY_EVENT_COUNTER_OVF_EN
    chk("sat_ovf_idle", ovf, 1);
`endif
    start = 1'b1; window_len = 8'd1;
    tick();
    start = 1'b0;
`ifdef MEALY_EVENT_COUNTER_OVF_EN
    chk("sat_ovf_clear", ovf, 0);
`endif
    chk("sat_restart_hi", rep_hi, 0);
    tick();
    chk("sat_w1_valid", rep_valid, 1);
    rep_ready = 1'b1;
    tick();
    rep_ready = 1'b0;

    // reset during the 4th COUNT cycle
    start = 1'b1; window_len = 8'd10;
    tick();
    start = 1'b0; o_in = 2'b01;
    tick(); tick(); tick();
    chk("mid_lo_before", rep_lo, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", rep_valid, 0);
    chk("mid_rst_lo", rep_lo, 0);
    tick();
    chk("mid_rst_hold_valid", rep_valid, 0);
    reset_n = 1'b1;
    start = 1'b1; window_len = 8'd3;
    tick();
    chk("post_rst_busy", busy, 1);
    start = 1'b0;
    tick(); tick();
    chk("post_rst_valid_early", rep_valid, 0);
    tick();
    chk("post_rst_valid", rep_valid, 1);
    chk("post_rst_lo", rep_lo, 3);

    // back-to-back: accept with start held high
    rep_ready = 1'b1; start = 1'b1; window_len = 8'd2; o_in = 2'b10;
    tick();
    chk("b2b_idle", busy, 0);
    rep_ready = 1'b0;
    tick();
    chk("b2b_busy", busy, 1);
    chk("b2b_lo_clear", rep_lo, 0);
    start = 1'b0;
    tick(); tick();
    chk("b2b_valid", rep_valid, 1);
    chk("b2b_hi", rep_hi, 2);
    chk("b2b_lo", rep_lo, 0);
    rep_ready = 1'b1;
    tick();
    chk("b2b_end", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mealy_event_counter.md
MEALY_EVENT_COUNTER -- requirements
Module: mealy_event_counter

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, which sets the event counter width.
REQ-002 The module SHALL have parameter WIN_W, default 8, which sets the window-length field width.
REQ-003 Port clock SHALL be an input, 1 bit wide: the single clock; all state changes happen on its rising edge.
REQ-004 Port reset_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-005 Port start SHALL be an input, 1 bit wide: request to open a counting window; sampled only in IDLE.
REQ-006 Port window_len SHALL be an input, WIN_W bits wide: number of clock cycles in the window; captured when start is accepted.
REQ-007 Port o_in SHALL be an input, 2 bits wide: the pattern detector output. Bit 1 means a "111" hit; bit 0 means a "001" hit.
REQ-008 Port busy SHALL be an output, 1 bit wide: high whenever the state is not IDLE.
REQ-009 Port rep_valid SHALL be an output, 1 bit wide: report available.
REQ-010 Port rep_ready SHALL be an input, 1 bit wide: the consumer accepts the report.
REQ-011 Port rep_hi SHALL be an output, CNT_W bits wide: number of o_in[1] hits in the window.
REQ-012 Port rep_lo SHALL be an output, CNT_W bits wide: number of o_in[0] hits in the window.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, COUNT and REPORT.
REQ-014 IDLE with start=1 SHALL move to COUNT on that edge if window_len is nonzero; counters clear to 0 and the remaining count loads window_len.
REQ-015 IDLE with start=1 and window_len=0 SHALL move directly to REPORT with both counters at 0.
REQ-016 In COUNT, each rising edge SHALL sample o_in: cnt_hi += o_in[1], cnt_lo += o_in[0], and remaining decrements by 1.
REQ-017 The first o_in sample SHALL be taken on the edge after the one that accepts start.
REQ-018 When o_in=2'b11 in one cycle, both counters SHALL increment in that same cycle; this is not an error.
REQ-019 Counters SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-020 On the edge that takes the sample with remaining=1, the FSM SHALL move to REPORT, so exactly window_len samples are counted.
REQ-021 rep_valid SHALL be high in REPORT and only in REPORT, starting the cycle after the last sample.
REQ-022 rep_hi and rep_lo SHALL show the live counters; in REPORT they SHALL hold steady until the report is accepted.
REQ-023 In REPORT, rep_valid=1 with rep_ready=1 on an edge SHALL transfer the report and move the FSM to IDLE.
REQ-024 REPORT with rep_ready=0 SHALL hold indefinitely; o_in is ignored in that state.
REQ-025 start SHALL be ignored in COUNT and REPORT; it never restarts or extends a window.
REQ-026 rep_valid SHALL NOT depend combinationally on rep_ready.
REQ-027 After the report transfers, a new start SHALL be acceptable no earlier than the following edge, from IDLE.

Reset
REQ-028 reset_n=0 SHALL immediately force: state IDLE, busy=0, rep_valid=0, counters 0, rep_hi=0, rep_lo=0, remaining 0, and ovf=0 when present.
REQ-029 A reset asserted mid-COUNT or mid-REPORT SHALL discard the window without emitting a report.
REQ-030 After reset_n rises, the first start SHALL be accepted on the first rising edge at which it is sampled.

Configuration
REQ-031 With macro MEALY_EVENT_COUNTER_OVF_EN defined, the module SHALL add output port ovf, 1 bit wide. ovf goes high when either counter would exceed its maximum within the current window, stays high through REPORT, and clears when the next start is accepted.
REQ-032 Without MEALY_EVENT_COUNTER_OVF_EN, the ovf port and its logic SHALL be absent, and saturation SHALL still apply.

Verification
REQ-033 Window: window_len=10, start pulse, then o_in sequence 00,00,10,00,00,01,00,00,00,01 -> rep_valid rises after the 10th sample; rep_hi=1, rep_lo=2; busy=1 throughout.
REQ-034 Empty window: window_len=0, start=1 -> REPORT on the next edge with rep_hi=0, rep_lo=0; rep_ready=1 -> IDLE on the following edge.
REQ-035 Backpressure: rep_ready=0 for 5 cycles in REPORT while o_in toggles and start=1 -> rep_valid stays 1 and counts are unchanged; rep_ready=1 -> IDLE, busy=0.
REQ-036 Saturation: CNT_W=4, window_len=20, o_in=2'b11 every cycle -> rep_hi=15, rep_lo=15; ovf=1 with the macro defined; a new start clears ovf.
REQ-037 Reset mid-window: reset_n=0 during the 4th cycle of COUNT -> outputs zero immediately and no rep_valid pulse; after release, window_len=3 with all o_in=01 -> rep_lo=3.
REQ-038 Back-to-back: report accepted with start held high -> one IDLE cycle, then a new window opens and the counters restart from 0.
